// File: rtl/mu0_mem_pkg.sv
// Shared types and constants for the MU0 block-RAM port-1 arbiter.
package mu0_mem_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOCK_M0,
        LOCK_M1
    } arb_state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_id_t;

    typedef struct packed {
        logic              req;
        logic              we;
        logic              lock;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: on contention the master that
// was not granted last wins.
module rr_pick2
    import mu0_mem_pkg::*;
(
    input  logic [1:0] req,
    input  master_id_t last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_gnt == M1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mu0_ram_arbiter.sv
// Two-master arbiter for RAM port 1: round-robin with a bounded lock for
// atomic read-modify-write, and read-response routing for the 1-cycle read.
module mu0_ram_arbiter #(
    parameter int unsigned ADDR_W          = mu0_mem_pkg::ADDR_W,
    parameter int unsigned DATA_W          = mu0_mem_pkg::DATA_W,
    parameter int unsigned MAX_LOCK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_write,
    output logic              ram_read,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    import mu0_mem_pkg::*;

    localparam logic [7:0] MaxLock = 8'(MAX_LOCK_CYCLES);

    arb_state_t state_q;
    master_id_t last_gnt_q;
    master_id_t rd_owner_q;
    logic [7:0] lock_cnt_q;
    logic       rd_pending_q;
    logic [1:0] lock_block_q;

    mem_req_t   req0, req1;
    logic [1:0] rr_gnt;
    logic [1:0] gnt;
    logic       accepted;
    master_id_t winner;
    logic              win_we;
    logic              win_lock;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    assign req0 = '{req: m0_req, we: m0_we, lock: m0_lock, addr: m0_addr, wdata: m0_wdata};
    assign req1 = '{req: m1_req, we: m1_we, lock: m1_lock, addr: m1_addr, wdata: m1_wdata};

    rr_pick2 u_pick (
        .req      ({req1.req, req0.req}),
        .last_gnt (last_gnt_q),
        .gnt      (rr_gnt)
    );

    // While locked only the owner can be granted; nothing is granted in reset.
    always_comb begin
        gnt = 2'b00;
        unique case (state_q)
            IDLE:    gnt = rr_gnt;
            LOCK_M0: gnt = {1'b0, req0.req};
            LOCK_M1: gnt = {req1.req, 1'b0};
            default: gnt = 2'b00;
        endcase
        if (!rst_n) begin
            gnt = 2'b00;
        end
    end

    assign m0_gnt   = gnt[0];
    assign m1_gnt   = gnt[1];
    assign accepted = |gnt;
    assign winner   = gnt[1] ? M1 : M0;

    always_comb begin
        win_we    = gnt[1] ? req1.we    : req0.we;
        win_lock  = gnt[1] ? req1.lock  : req0.lock;
        win_addr  = gnt[1] ? req1.addr  : req0.addr;
        win_wdata = gnt[1] ? req1.wdata : req0.wdata;
    end

    assign ram_addr  = accepted ? win_addr  : '0;
    assign ram_wdata = accepted ? win_wdata : '0;
    assign ram_write = accepted & win_we;
    assign ram_read  = accepted & ~win_we;

    assign m0_rvalid = rd_pending_q && (rd_owner_q == M0);
    assign m1_rvalid = rd_pending_q && (rd_owner_q == M1);
    assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
    assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_gnt_q   <= M1;
            rd_owner_q   <= M0;
            lock_cnt_q   <= 8'd0;
            rd_pending_q <= 1'b0;
            lock_block_q <= 2'b00;
        end else begin
            rd_pending_q <= accepted & ~win_we;
            if (accepted) begin
                last_gnt_q <= winner;
                rd_owner_q <= winner;
            end
            if (!m0_lock) lock_block_q[0] <= 1'b0;
            if (!m1_lock) lock_block_q[1] <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (accepted && win_lock && !lock_block_q[winner]) begin
                        state_q    <= (winner == M0) ? LOCK_M0 : LOCK_M1;
                        lock_cnt_q <= 8'd1;
                    end
                end
                LOCK_M0: begin
                    // Forced release hands the next contention to m1.
                    if (lock_cnt_q == MaxLock) begin
                        state_q         <= IDLE;
                        last_gnt_q      <= M0;
                        lock_block_q[0] <= 1'b1;
                        lock_cnt_q      <= 8'd0;
                    end else if (!m0_lock) begin
                        state_q    <= IDLE;
                        lock_cnt_q <= 8'd0;
                    end else if (lock_cnt_q < MaxLock) begin
                        lock_cnt_q <= lock_cnt_q + 8'd1;
                    end
                end
                LOCK_M1: begin
                    if (lock_cnt_q == MaxLock) begin
                        state_q         <= IDLE;
                        last_gnt_q      <= M1;
                        lock_block_q[1] <= 1'b1;
                        lock_cnt_q      <= 8'd0;
                    end else if (!m1_lock) begin
                        state_q    <= IDLE;
                        lock_cnt_q <= 8'd0;
                    end else if (lock_cnt_q < MaxLock) begin
                        lock_cnt_q <= lock_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    lock_cnt_q <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mu0_ram_arbiter.sv
// Self-checking bench for mu0_ram_arbiter with a behavioural 1-cycle RAM and
// a scoreboard of expected read responses.
module tb_mu0_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
    logic [11:0] m0_addr;
    logic [15:0] m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [11:0] m1_addr;
    logic [15:0] m1_wdata, m1_rdata;
    logic [11:0] ram_addr;
    logic        ram_write, ram_read;
    logic [15:0] ram_wdata, ram_rdata;

    mu0_ram_arbiter #(
        .ADDR_W          (12),
        .DATA_W          (16),
        .MAX_LOCK_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_lock   (m0_lock),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_lock   (m1_lock),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .ram_addr  (ram_addr),
        .ram_write (ram_write),
        .ram_read  (ram_read),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM port: registered read returns the pre-write contents.
    logic [15:0] mem [0:4095];
    always @(posedge clk) begin
        if (ram_read)  ram_rdata <= mem[ram_addr];
        if (ram_write) mem[ram_addr] <= ram_wdata;
    end

    typedef struct {
        logic        own;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] shadow [0:4095];
    int          cyc;
    int          n_cmp;
    int          n_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drv0(input logic r, input logic w, input logic l,
                        input logic [11:0] a, input logic [15:0] d);
        m0_req = r; m0_we = w; m0_lock = l; m0_addr = a; m0_wdata = d;
    endtask

    task automatic drv1(input logic r, input logic w, input logic l,
                        input logic [11:0] a, input logic [15:0] d);
        m1_req = r; m1_we = w; m1_lock = l; m1_addr = a; m1_wdata = d;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_rvalid"}, {m0_rvalid, m1_rvalid}, 2'b00);
        check_eq({tag, "_rdata"}, {m0_rdata, m1_rdata}, 32'h0);
        check_eq({tag, "_ram"}, {ram_write, ram_read, ram_addr, ram_wdata}, 30'h0);
    endtask

    // One clock cycle: inputs are already driven; e0/e1 are the expected grants.
    task automatic cycle(input logic e0, input logic e1);
        exp_t        e;
        logic        w;
        logic [11:0] a;
        logic [15:0] wd;
        @(negedge clk);
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check_eq("m0_rvalid", m0_rvalid, !e.own);
            check_eq("m1_rvalid", m1_rvalid, e.own);
            check_eq("m0_rdata", m0_rdata, e.own ? 16'h0 : e.data);
            check_eq("m1_rdata", m1_rdata, e.own ? e.data : 16'h0);
        end else begin
            check_eq("rvalid_idle", {m0_rvalid, m1_rvalid}, 2'b00);
            check_eq("rdata_idle", {m0_rdata, m1_rdata}, 32'h0);
        end
        check_eq("m0_gnt", m0_gnt, e0);
        check_eq("m1_gnt", m1_gnt, e1);
        if (e0 || e1) begin
            w  = e1 ? m1_we    : m0_we;
            a  = e1 ? m1_addr  : m0_addr;
            wd = e1 ? m1_wdata : m0_wdata;
            check_eq("ram_drive", {ram_write, ram_read, ram_addr, ram_wdata}, {w, ~w, a, wd});
            if (w) shadow[a] = wd;
            else   sb.push_back('{own: e1, data: shadow[a], due: cyc + 1});
        end else begin
            check_eq("ram_nognt", {ram_write, ram_read, ram_addr, ram_wdata}, 30'h0);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic exp0;
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        rst_n = 1'b0;
        drv0(1'b1, 1'b0, 1'b1, 12'h010, 16'h0);
        drv1(1'b1, 1'b0, 1'b1, 12'h020, 16'h0);

        // Reset held with both masters requesting.
        repeat (2) begin
            @(negedge clk);
            check_eq("rst_gnt", {m0_gnt, m1_gnt}, 2'b00);
            check_quiet("rst");
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;

        // Preload via writes; first contention after reset goes to m0.
        drv0(1'b1, 1'b1, 1'b0, 12'h010, 16'hAAAA);
        drv1(1'b1, 1'b1, 1'b0, 12'h020, 16'h5555);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        drv0(1'b0, 1'b0, 1'b0, 12'h000, 16'h0);
        drv1(1'b1, 1'b1, 1'b0, 12'h005, 16'h0F0F);
        cycle(1'b0, 1'b1);

        // Continuous contention reads alternate.
        drv0(1'b1, 1'b0, 1'b0, 12'h010, 16'h0);
        drv1(1'b1, 1'b0, 1'b0, 12'h020, 16'h0);
        repeat (3) begin
            cycle(1'b1, 1'b0);
            cycle(1'b0, 1'b1);
        end
        drv0(1'b0, 1'b0, 1'b0, 12'h000, 16'h0);
        drv1(1'b0, 1'b0, 1'b0, 12'h000, 16'h0);
        cycle(1'b0, 1'b0);

        // Write then read at the top address.
        drv1(1'b1, 1'b1, 1'b0, 12'hFFF, 16'h1234);
        cycle(1'b0, 1'b1);
        drv1(1'b1, 1'b0, 1'b0, 12'hFFF, 16'h0);
        cycle(1'b0, 1'b1);
        drv1(1'b0, 1'b0, 1'b0, 12'h000, 16'h0);
        cycle(1'b0, 1'b0);

        // Voluntary lock: read-modify-write by m0 with m1 waiting.
        drv0(1'b1, 1'b0, 1'b1, 12'h005, 16'h0);
        drv1(1'b1, 1'b0, 1'b0, 12'h020, 16'h0);
        cycle(1'b1, 1'b0);
        drv0(1'b1, 1'b0, 1'b1, 12'h010, 16'h0);
        cycle(1'b1, 1'b0);
        drv0(1'b0, 1'b0, 1'b1, 12'h000, 16'h0);
        cycle(1'b0, 1'b0);
        drv0(1'b1, 1'b1, 1'b0, 12'h005, 16'hBEEF);
        cycle(1'b1, 1'b0);
        drv0(1'b1, 1'b0, 1'b0, 12'h005, 16'h0);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        drv0(1'b0, 1'b0, 1'b0, 12'h000, 16'h0);
        cycle(1'b0, 1'b1);

        // Forced release after 16 locked cycles, then no re-lock while blocked.
        drv0(1'b1, 1'b0, 1'b1, 12'h005, 16'h0);
        for (int i = 0; i < 40; i++) begin
            exp0 = (i <= 16) || (((i - 17) % 2) == 1);
            cycle(exp0, !exp0);
        end
        drv0(1'b1, 1'b0, 1'b0, 12'h005, 16'h0);
        cycle(1'b1, 1'b0);
        drv0(1'b1, 1'b0, 1'b1, 12'h005, 16'h0);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        drv0(1'b1, 1'b0, 1'b0, 12'h005, 16'h0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        drv0(1'b0, 1'b0, 1'b0, 12'h000, 16'h0);
        drv1(1'b0, 1'b0, 1'b0, 12'h000, 16'h0);
        cycle(1'b0, 1'b0);

        // Reset lands while a locked m0 read response is pending.
        drv0(1'b1, 1'b0, 1'b1, 12'h010, 16'h0);
        cycle(1'b1, 1'b0);
        rst_n = 1'b0;
        drv0(1'b0, 1'b0, 1'b0, 12'h000, 16'h0);
        sb.delete();
        repeat (2) begin
            @(negedge clk);
            check_quiet("rst_mid");
            @(posedge clk);
            #1;
            cyc++;
        end
        rst_n = 1'b1;
        drv1(1'b1, 1'b0, 1'b0, 12'h020, 16'h0);
        cycle(1'b0, 1'b1);
        drv0(1'b1, 1'b0, 1'b0, 12'h010, 16'h0);
        cycle(1'b1, 1'b0);
        drv0(1'b0, 1'b0, 1'b0, 12'h000, 16'h0);
        drv1(1'b0, 1'b0, 1'b0, 12'h000, 16'h0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
